// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with a manual mode and an auto-scan mode.
// Define MUX_SCAN_PARITY_EN to add out_par, the registered even parity of the selected channel.
//
// state  | meaning
// IDLE   | disabled; outputs hold, out_valid low, scan position frozen
// MANUAL | out follows channel sel, one cycle late
// SCAN   | out steps through the channels, holding each one for DWELL cycles
module mux_scan_n #(
    parameter  int N     = 16,
    parameter  int W     = 1,
    parameter  int DWELL = 1,
    localparam int SELW  = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_bus,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    out,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic            out_par
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [15:0]     DWELL_LAST = 16'(DWELL - 1);
    localparam logic [SELW-1:0] IDX_LAST   = SELW'(N - 1);

    state_t          state;
    logic [SELW-1:0] idx;
    logic [15:0]     dwell;

    logic [W-1:0]    sel_data;
    logic            sel_ok;
    logic            entering;
    logic [SELW-1:0] cur_idx;
    logic [15:0]     cur_dwell;
    logic [W-1:0]    scan_data;
    logic            scan_last;
    logic [SELW-1:0] nxt_idx;

    // Decoded mux: an out-of-range select matches nothing, so the result is 0 rather than X.
    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                sel_data = in_bus[k*W +: W];
                sel_ok   = 1'b1;
            end
        end
    end

    // The entry cycle into SCAN is also the first dwell cycle of the start channel,
    // so the start position is taken straight from sel and the count starts from zero.
    always_comb begin
        entering  = (state != SCAN);
        cur_idx   = entering ? (sel_ok ? sel : '0) : idx;
        cur_dwell = entering ? '0 : dwell;
        scan_last = (cur_dwell == DWELL_LAST);
        nxt_idx   = (cur_idx == IDX_LAST) ? '0 : cur_idx + SELW'(1);
    end

    always_comb begin
        scan_data = '0;
        for (int k = 0; k < N; k++) begin
            if (cur_idx == SELW'(k)) begin
                scan_data = in_bus[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            dwell     <= '0;
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else if (!en) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else if (!mode) begin
            state     <= MANUAL;
            out       <= sel_data;
            out_sel   <= sel;
            out_valid <= sel_ok;
`ifdef MUX_SCAN_PARITY_EN
            out_par   <= ^sel_data;
`endif
        end else begin
            state     <= SCAN;
            out       <= scan_data;
            out_sel   <= cur_idx;
            out_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            out_par   <= ^scan_data;
`endif
            if (scan_last) begin
                dwell <= '0;
                idx   <= nxt_idx;
            end else begin
                dwell <= cur_dwell + 16'd1;
                idx   <= cur_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: a 16x1 single-dwell instance and a 12x8 three-cycle-dwell instance.
module tb_mux_scan_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [15:0] in_a;
    logic [3:0]  sel_a;
    logic        mode_a, en_a;
    logic        out_a;
    logic [3:0]  out_sel_a;
    logic        valid_a;

    logic [95:0] in_b;
    logic [3:0]  sel_b;
    logic        mode_b, en_b;
    logic [7:0]  out_b;
    logic [3:0]  out_sel_b;
    logic        valid_b;
`ifdef MUX_SCAN_PARITY_EN
    logic        par_a, par_b;
`endif

    int checks   = 0;
    int failures = 0;

    mux_scan_n #(.N(16), .W(1), .DWELL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(in_a), .sel(sel_a), .mode(mode_a), .en(en_a),
        .out(out_a), .out_sel(out_sel_a), .out_valid(valid_a)
`ifdef MUX_SCAN_PARITY_EN
        , .out_par(par_a)
`endif
    );

    mux_scan_n #(.N(12), .W(8), .DWELL(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(in_b), .sel(sel_b), .mode(mode_b), .en(en_b),
        .out(out_b), .out_sel(out_sel_b), .out_valid(valid_b)
`ifdef MUX_SCAN_PARITY_EN
        , .out_par(par_b)
`endif
    );

    function automatic logic [7:0] ch_b(int k);
        return (k == 11) ? 8'hA5 : 8'(16 + k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_a !== 1'b0 || out_sel_a !== 4'd0 || valid_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a out=%0b sel=%0d valid=%0b expected 0/0/0", out_a, out_sel_a, valid_a);
        end
        checks++;
        if (out_b !== 8'h00 || out_sel_b !== 4'd0 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b out=%0h sel=%0d valid=%0b expected 0/0/0", out_b, out_sel_b, valid_b);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_release valid_a=%0b valid_b=%0b expected 0", valid_a, valid_b);
        end
    endtask

    task automatic test_walking();
        en_a = 1'b1;
        mode_a = 1'b0;
        for (int s = 0; s < 16; s++) begin
            sel_a = 4'(s);
            in_a  = ~(16'h0001 << s);
            tick();
            checks++;
            if (out_a !== 1'b0 || out_sel_a !== 4'(s) || valid_a !== 1'b1) begin
                failures++;
                $display("FAIL walk0 sel=%0d out=%0b out_sel=%0d valid=%0b expected 0/%0d/1",
                         s, out_a, out_sel_a, valid_a, s);
            end
            in_a = 16'h0001 << s;
            tick();
            checks++;
            if (out_a !== 1'b1 || out_sel_a !== 4'(s) || valid_a !== 1'b1) begin
                failures++;
                $display("FAIL walk1 sel=%0d out=%0b out_sel=%0d valid=%0b expected 1/%0d/1",
                         s, out_a, out_sel_a, valid_a, s);
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 12; k++) in_b[k*8 +: 8] = ch_b(k);
        en_b = 1'b1;
        mode_b = 1'b0;
        sel_b = 4'd13;
        tick();
        checks++;
        if (out_b !== 8'h00 || valid_b !== 1'b0 || out_sel_b !== 4'd13) begin
            failures++;
            $display("FAIL sel_oob out=%0h valid=%0b out_sel=%0d expected 00/0/13", out_b, valid_b, out_sel_b);
        end
        sel_b = 4'd11;
        tick();
        checks++;
        if (out_b !== 8'hA5 || valid_b !== 1'b1 || out_sel_b !== 4'd11) begin
            failures++;
            $display("FAIL sel_11 out=%0h valid=%0b out_sel=%0d expected a5/1/11", out_b, valid_b, out_sel_b);
        end
    endtask

    task automatic test_scan_dwell();
        int exp_seq[10] = '{10, 10, 10, 11, 11, 11, 0, 0, 0, 1};
        sel_b = 4'd10;
        mode_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_sel_b !== 4'(exp_seq[i]) || out_b !== ch_b(exp_seq[i]) || valid_b !== 1'b1) begin
                failures++;
                $display("FAIL scan_dwell step=%0d out_sel=%0d out=%0h valid=%0b expected %0d/%0h/1",
                         i, out_sel_b, out_b, valid_b, exp_seq[i], ch_b(exp_seq[i]));
            end
        end
    endtask

    task automatic test_pause_restart();
        int e;
        in_a = 16'h0020;
        sel_a = 4'd3;
        mode_a = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (out_sel_a !== 4'd5 || out_a !== 1'b1 || valid_a !== 1'b1) begin
            failures++;
            $display("FAIL scan_to_5 out_sel=%0d out=%0b valid=%0b expected 5/1/1", out_sel_a, out_a, valid_a);
        end
        en_a = 1'b0;
        in_a = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (valid_a !== 1'b0 || out_a !== 1'b1 || out_sel_a !== 4'd5) begin
                failures++;
                $display("FAIL pause cyc=%0d valid=%0b out=%0b out_sel=%0d expected 0/1/5",
                         i, valid_a, out_a, out_sel_a);
            end
        end
        en_a = 1'b1;
        sel_a = 4'd2;
        in_a = 16'h0004;
        tick();
        checks++;
        if (out_sel_a !== 4'd2 || out_a !== 1'b1 || valid_a !== 1'b1) begin
            failures++;
            $display("FAIL restart out_sel=%0d out=%0b valid=%0b expected 2/1/1", out_sel_a, out_a, valid_a);
        end
        for (int k = 1; k < 16; k++) begin
            e = (2 + k) % 16;
            tick();
            checks++;
            if (out_sel_a !== 4'(e) || out_a !== (e == 2) || valid_a !== 1'b1) begin
                failures++;
                $display("FAIL sweep k=%0d out_sel=%0d out=%0b expected %0d/%0b", k, out_sel_a, out_a, e, (e == 2));
            end
        end
    endtask

    task automatic test_mode_switch();
        mode_a = 1'b0;
        sel_a = 4'd7;
        in_a = 16'h0080;
        tick();
        checks++;
        if (out_sel_a !== 4'd7 || out_a !== 1'b1 || valid_a !== 1'b1) begin
            failures++;
            $display("FAIL scan_to_manual out_sel=%0d out=%0b valid=%0b expected 7/1/1", out_sel_a, out_a, valid_a);
        end
        in_a = 16'h0000;
        tick();
        checks++;
        if (out_a !== 1'b0 || out_sel_a !== 4'd7) begin
            failures++;
            $display("FAIL manual_latency out=%0b out_sel=%0d expected 0/7", out_a, out_sel_a);
        end
    endtask

    task automatic test_reset_mid();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_b !== 8'h00 || out_sel_b !== 4'd0 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid out=%0h out_sel=%0d valid=%0b expected 0/0/0", out_b, out_sel_b, valid_b);
        end
`ifdef MUX_SCAN_PARITY_EN
        checks++;
        if (par_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_par par=%0b expected 0", par_b);
        end
`endif
        en_b = 1'b0;
        en_a = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (valid_b !== 1'b0 || out_b !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_idle valid=%0b out=%0h expected 0/00", valid_b, out_b);
        end
        en_b = 1'b1;
        mode_b = 1'b1;
        sel_b = 4'd4;
        tick();
        checks++;
        if (valid_b !== 1'b1 || out_sel_b !== 4'd4 || out_b !== ch_b(4)) begin
            failures++;
            $display("FAIL post_reset_scan valid=%0b out_sel=%0d out=%0h expected 1/4/%0h",
                     valid_b, out_sel_b, out_b, ch_b(4));
        end
    endtask

    task automatic test_parity();
        mode_b = 1'b0;
        sel_b = 4'd3;
        in_b[31:24] = 8'h07;
        tick();
        checks++;
        if (out_b !== 8'h07 || valid_b !== 1'b1) begin
            failures++;
            $display("FAIL par_data out=%0h valid=%0b expected 07/1", out_b, valid_b);
        end
`ifdef MUX_SCAN_PARITY_EN
        checks++;
        if (par_b !== 1'b1) begin
            failures++;
            $display("FAIL par_07 par=%0b expected 1", par_b);
        end
`endif
        sel_b = 4'd11;
        tick();
        checks++;
        if (out_b !== 8'hA5) begin
            failures++;
            $display("FAIL par_a5_data out=%0h expected a5", out_b);
        end
`ifdef MUX_SCAN_PARITY_EN
        checks++;
        if (par_b !== 1'b0) begin
            failures++;
            $display("FAIL par_a5 par=%0b expected 0", par_b);
        end
`endif
    endtask

    initial begin
        rst_n  = 1'b1;
        in_a   = '0;
        sel_a  = '0;
        mode_a = 1'b0;
        en_a   = 1'b0;
        in_b   = '0;
        sel_b  = '0;
        mode_b = 1'b0;
        en_b   = 1'b0;
        #1;
        test_reset();
        test_walking();
        test_out_of_range();
        test_scan_dwell();
        test_pause_restart();
        test_mode_switch();
        test_reset_mid();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
- REQ-001 The block SHALL have parameter N, default 16: number of input channels, 2..256.
- REQ-002 The block SHALL have parameter W, default 1: bits per channel, 1..64.
- REQ-003 The block SHALL have parameter DWELL, default 1: cycles each channel is held in scan mode, 1..65535.
- REQ-004 The block SHALL derive local SELW = clog2(N), with minimum 1.
- REQ-005 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-006 The block SHALL have port rst_n, input, 1: reset, asynchronous assertion, active-low.
- REQ-007 The block SHALL have port in_bus, input, N*W: channel k occupies bits [k*W+W-1 : k*W].
- REQ-008 The block SHALL have port sel, input, SELW: manual channel select.
- REQ-009 The block SHALL have port mode, input, 1: 0 selects manual, 1 selects auto-scan.
- REQ-010 The block SHALL have port en, input, 1: operation enable.
- REQ-011 The block SHALL have port out, output, W: registered selected channel data.
- REQ-012 The block SHALL have port out_sel, output, SELW: channel index that produced out.
- REQ-013 The block SHALL have port out_valid, output, 1: out/out_sel valid this cycle.
- REQ-014 The block SHALL have port out_par, output, 1: present only with MUX_SCAN_PARITY_EN.

Function
- REQ-015 The block SHALL implement FSM states IDLE, MANUAL and SCAN; the state register SHALL reset to IDLE.
- REQ-016 IDLE SHALL go to MANUAL when en=1 and mode=0; IDLE SHALL go to SCAN when en=1 and mode=1.
- REQ-017 MANUAL SHALL go to SCAN and SCAN SHALL go to MANUAL on a mode change while en=1; en=0 SHALL return any state to IDLE.
- REQ-018 MANUAL: each cycle, out SHALL capture channel sel and out_sel SHALL capture sel, with out_valid=1; latency 1 cycle from sel/in_bus to out.
- REQ-019 MANUAL with sel >= N: out=0, out_sel=sel and out_valid=0 SHALL be registered; no X propagation is allowed.
- REQ-020 SCAN entry: the scan index SHALL load from sel when sel < N, else from 0, and the dwell counter SHALL clear.
- REQ-021 SCAN: out SHALL capture channel idx each cycle and out_valid SHALL be 1; the dwell counter SHALL increment each cycle.
- REQ-022 SCAN: when the dwell counter reaches DWELL-1 it SHALL clear and idx SHALL advance by 1.
- REQ-023 SCAN wrap: idx = N-1 SHALL advance to 0, including non-power-of-two N.
- REQ-024 SCAN with DWELL=1: idx SHALL advance every cycle, giving a full sweep in N cycles.
- REQ-025 IDLE: out, out_sel and out_par SHALL hold their last values, out_valid SHALL be 0, and the scan index and dwell counter SHALL freeze.
- REQ-026 Re-entering SCAN from IDLE SHALL reload per REQ-020; scan position SHALL not resume.
- REQ-027 Changes to in_bus SHALL be visible at out one cycle later in both modes; no internal input staging beyond the output register is allowed.

Reset
- REQ-028 rst_n=0 SHALL immediately force state=IDLE, out=0, out_sel=0, out_valid=0, out_par=0, idx=0 and dwell counter=0, regardless of clk.
- REQ-029 Reset asserted mid-scan SHALL abort the scan; after release, the first valid output SHALL appear one cycle after en=1 is sampled.
- REQ-030 Release of rst_n SHALL not itself generate out_valid.

Configuration
- REQ-031 With macro MUX_SCAN_PARITY_EN defined, out_par SHALL exist and SHALL be the registered even parity (XOR) of the selected channel, aligned with out and 0 when out_valid=0 due to sel >= N.
- REQ-032 With MUX_SCAN_PARITY_EN undefined, the out_par port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-033 Walking-zero/one, N=16, W=1, manual mode: for each sel 0..15, in_bus = ~(1<<sel) SHALL give out=0 and in_bus = (1<<sel) SHALL give out=1 next cycle, with out_sel=sel.
- REQ-034 N=12, W=8, sel=13, manual mode: out SHALL be 0x00 and out_valid SHALL be 0; then sel=11 with channel 11=0xA5 SHALL give out=0xA5 and out_valid=1 next cycle.
- REQ-035 N=12, DWELL=3, scan mode from sel=10: out_sel sequence SHALL be 10,10,10,11,11,11,0,0,0,1...
- REQ-036 Scan mode at idx=5, deassert en for 4 cycles: out_valid SHALL be 0 and out SHALL hold; re-assert en with sel=2: scan SHALL restart at 2.
- REQ-037 Assert rst_n=0 between clock edges mid-scan: all outputs SHALL be 0 within the same cycle; with MUX_SCAN_PARITY_EN, W=8, channel data 0x07 SHALL give out_par=1.
